// File: rtl/cmplx_pkg.sv
// rtl/cmplx_pkg.sv - shared widths, latency and output formatting for the complex MAC
package cmplx_pkg;

   localparam int A_WIDTH_DEF   = 16;
   localparam int B_WIDTH_DEF   = 16;
   localparam int O_WIDTH_DEF   = 24;
   localparam int LEN_WIDTH_DEF = 8;

   // Multiplier pipeline depth measured from the input capture register.
   localparam int MUL_LAT = 4;

   // Formatting runs on a 64-bit signed value; callers sign-extend into it.
   typedef struct packed {
      logic [63:0] val;
      logic        sat;
   } fmt_t;

   // Round half up by 2^(sh-1), arithmetic shift right, then clamp to ow bits.
   function automatic fmt_t round_sat(input logic signed [63:0] x,
                                      input logic [5:0]         sh,
                                      input int                 ow);
      fmt_t                r;
      logic signed [63:0]  v;
      logic signed [63:0]  hi;
      logic signed [63:0]  lo;
      v = x;
      if (sh != 6'd0) begin
         v = (x + (64'sd1 <<< (sh - 6'd1))) >>> sh;
      end
      hi    = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      r.val = v;
      r.sat = 1'b0;
      if (v > hi) begin
         r.val = hi;
         r.sat = 1'b1;
      end else if (v < lo) begin
         r.val = lo;
         r.sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cmplx_mul_pipe.sv
// rtl/cmplx_mul_pipe.sv - ce-gated 3-multiplier complex product pipeline with conjugate option
module cmplx_mul_pipe
   import cmplx_pkg::*;
#(
   parameter int AWIDTH = A_WIDTH_DEF,
   parameter int BWIDTH = B_WIDTH_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ce,
   input  logic                            in_valid,
   input  logic                            conj,
   input  logic signed [AWIDTH-1:0]        ar,
   input  logic signed [AWIDTH-1:0]        ai,
   input  logic signed [BWIDTH-1:0]        br,
   input  logic signed [BWIDTH-1:0]        bi,
   output logic                            out_valid,
   output logic signed [AWIDTH+BWIDTH:0]   pr,
   output logic signed [AWIDTH+BWIDTH:0]   pi
);

   localparam int AW1 = AWIDTH + 1;
   localparam int BW1 = BWIDTH + 1;
   localparam int BW2 = BWIDTH + 2;
   localparam int MW  = AWIDTH + BWIDTH + 2;
   localparam int PW  = AWIDTH + BWIDTH + 1;

   // stage 0: input capture, bi already conjugated (one extra bit keeps -min exact)
   logic                    v0_q, v0_d;
   logic signed [AWIDTH-1:0] ar0_q, ar0_d, ai0_q, ai0_d;
   logic signed [BWIDTH-1:0] br0_q, br0_d;
   logic signed [BW1-1:0]    bi0_q, bi0_d;
   // stage 1: pre-adders
   logic                    v1_q, v1_d;
   logic signed [AWIDTH-1:0] ar1_q, ar1_d, ai1_q, ai1_d;
   logic signed [AW1-1:0]    dab1_q, dab1_d;
   logic signed [BW1-1:0]    bi1_q, bi1_d;
   logic signed [BW2-1:0]    bsub1_q, bsub1_d, badd1_q, badd1_d;
   // stage 2 and 3: multiply, then a second register so the multiply can be retimed
   logic                    v2_q, v2_d, v3_q, v3_d;
   logic signed [MW-1:0]     m1_2_q, m1_2_d, m2_2_q, m2_2_d, m3_2_q, m3_2_d;
   logic signed [MW-1:0]     m1_3_q, m1_3_d, m2_3_q, m2_3_d, m3_3_q, m3_3_d;
   // stage 4: post-adders; true results always fit PW so modular truncation is exact
   logic                    v4_q, v4_d;
   logic signed [PW-1:0]     pr4_q, pr4_d, pi4_q, pi4_d;

   logic signed [BW1-1:0]    bi_ext;

   // next-state for every stage; nothing moves unless ce
   always_comb begin
      v0_d = v0_q;  ar0_d = ar0_q;  ai0_d = ai0_q;  br0_d = br0_q;  bi0_d = bi0_q;
      v1_d = v1_q;  ar1_d = ar1_q;  ai1_d = ai1_q;  dab1_d = dab1_q;  bi1_d = bi1_q;
      bsub1_d = bsub1_q;  badd1_d = badd1_q;
      v2_d = v2_q;  m1_2_d = m1_2_q;  m2_2_d = m2_2_q;  m3_2_d = m3_2_q;
      v3_d = v3_q;  m1_3_d = m1_3_q;  m2_3_d = m2_3_q;  m3_3_d = m3_3_q;
      v4_d = v4_q;  pr4_d = pr4_q;  pi4_d = pi4_q;
      bi_ext = BW1'(bi);
      if (ce) begin
         v0_d    = in_valid;
         ar0_d   = ar;
         ai0_d   = ai;
         br0_d   = br;
         bi0_d   = conj ? -bi_ext : bi_ext;

         v1_d    = v0_q;
         ar1_d   = ar0_q;
         ai1_d   = ai0_q;
         dab1_d  = AW1'(ar0_q) - AW1'(ai0_q);
         bi1_d   = bi0_q;
         bsub1_d = BW2'(br0_q) - BW2'(bi0_q);
         badd1_d = BW2'(br0_q) + BW2'(bi0_q);

         v2_d    = v1_q;
         m1_2_d  = MW'(ar1_q) * MW'(bsub1_q);
         m2_2_d  = MW'(ai1_q) * MW'(badd1_q);
         m3_2_d  = MW'(dab1_q) * MW'(bi1_q);

         v3_d    = v2_q;
         m1_3_d  = m1_2_q;
         m2_3_d  = m2_2_q;
         m3_3_d  = m3_2_q;

         v4_d    = v3_q;
         pr4_d   = PW'(m1_3_q + m3_3_q);
         pi4_d   = PW'(m2_3_q + m3_3_q);
      end
   end

   // pipeline registers; only the valid bits need clearing, data is cleared for tidiness
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0_q <= 1'b0;  ar0_q <= '0;  ai0_q <= '0;  br0_q <= '0;  bi0_q <= '0;
         v1_q <= 1'b0;  ar1_q <= '0;  ai1_q <= '0;  dab1_q <= '0;  bi1_q <= '0;
         bsub1_q <= '0; badd1_q <= '0;
         v2_q <= 1'b0;  m1_2_q <= '0; m2_2_q <= '0; m3_2_q <= '0;
         v3_q <= 1'b0;  m1_3_q <= '0; m2_3_q <= '0; m3_3_q <= '0;
         v4_q <= 1'b0;  pr4_q <= '0;  pi4_q <= '0;
      end else begin
         v0_q <= v0_d;  ar0_q <= ar0_d;  ai0_q <= ai0_d;  br0_q <= br0_d;  bi0_q <= bi0_d;
         v1_q <= v1_d;  ar1_q <= ar1_d;  ai1_q <= ai1_d;  dab1_q <= dab1_d;  bi1_q <= bi1_d;
         bsub1_q <= bsub1_d; badd1_q <= badd1_d;
         v2_q <= v2_d;  m1_2_q <= m1_2_d; m2_2_q <= m2_2_d; m3_2_q <= m3_2_d;
         v3_q <= v3_d;  m1_3_q <= m1_3_d; m2_3_q <= m2_3_d; m3_3_q <= m3_3_d;
         v4_q <= v4_d;  pr4_q <= pr4_d;  pi4_q <= pi4_d;
      end
   end

   assign out_valid = v4_q;
   assign pr        = pr4_q;
   assign pi        = pi4_q;

endmodule

// File: rtl/cmplx_mac.sv
// rtl/cmplx_mac.sv - complex multiply-accumulate with framed sums, rounding and saturation
module cmplx_mac
   import cmplx_pkg::*;
#(
   parameter int AWIDTH = A_WIDTH_DEF,
   parameter int BWIDTH = B_WIDTH_DEF,
   parameter int OWIDTH = O_WIDTH_DEF,
   parameter int LENW   = LEN_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [AWIDTH-1:0] ar,
   input  logic signed [AWIDTH-1:0] ai,
   input  logic signed [BWIDTH-1:0] br,
   input  logic signed [BWIDTH-1:0] bi,
   input  logic                     conj,
   input  logic [LENW-1:0]          acc_len,
   input  logic [5:0]               shift,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OWIDTH-1:0] pr,
   output logic signed [OWIDTH-1:0] pi,
   output logic                     sat_flag
);

   localparam int PW   = AWIDTH + BWIDTH + 1;
   localparam int ACCW = PW + LENW;

   logic                    ce;
   logic                    m_valid;
   logic signed [PW-1:0]    m_pr, m_pi;

   logic signed [ACCW-1:0]  acc_r_q, acc_r_d, acc_i_q, acc_i_d;
   logic [LENW-1:0]         cnt_q, cnt_d, len_q, len_d;
   logic [5:0]              shift_q, shift_d;
   logic                    sum_valid_q, sum_valid_d;
   logic [LENW-1:0]         len_eff, cnt_next;

   logic                    out_valid_q, out_valid_d;
   logic signed [OWIDTH-1:0] pr_q, pr_d, pi_q, pi_d;
   logic                    sat_q, sat_d;
   fmt_t                    fmt_r, fmt_i;

   // A full output register that is not being drained freezes the whole datapath.
   assign ce       = !out_valid_q | out_ready;
   assign in_ready = ce;

   cmplx_mul_pipe #(
      .AWIDTH (AWIDTH),
      .BWIDTH (BWIDTH)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (in_valid),
      .conj      (conj),
      .ar        (ar),
      .ai        (ai),
      .br        (br),
      .bi        (bi),
      .out_valid (m_valid),
      .pr        (m_pr),
      .pi        (m_pi)
   );

   // accumulator: the first product of a frame reloads the sum and latches length/shift
   always_comb begin
      acc_r_d     = acc_r_q;
      acc_i_d     = acc_i_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      shift_d     = shift_q;
      sum_valid_d = sum_valid_q;
      len_eff     = len_q;
      cnt_next    = cnt_q;
      if (ce) begin
         sum_valid_d = 1'b0;
         if (m_valid) begin
            if (cnt_q == '0) begin
               len_eff  = (acc_len == '0) ? LENW'(1) : acc_len;
               len_d    = len_eff;
               shift_d  = shift;
               acc_r_d  = ACCW'(m_pr);
               acc_i_d  = ACCW'(m_pi);
               cnt_next = LENW'(1);
            end else begin
               acc_r_d  = acc_r_q + ACCW'(m_pr);
               acc_i_d  = acc_i_q + ACCW'(m_pi);
               cnt_next = cnt_q + LENW'(1);
            end
            if (cnt_next == len_eff) begin
               sum_valid_d = 1'b1;
               cnt_d       = '0;
            end else begin
               cnt_d       = cnt_next;
            end
         end
      end
   end

   // output register: format a completed frame sum with the shift latched for that frame
   always_comb begin
      out_valid_d = out_valid_q;
      pr_d        = pr_q;
      pi_d        = pi_q;
      sat_d       = sat_q;
      fmt_r       = round_sat(64'(acc_r_q), shift_q, OWIDTH);
      fmt_i       = round_sat(64'(acc_i_q), shift_q, OWIDTH);
      if (ce) begin
         out_valid_d = sum_valid_q;
         if (sum_valid_q) begin
            pr_d  = OWIDTH'(fmt_r.val);
            pi_d  = OWIDTH'(fmt_i.val);
            sat_d = fmt_r.sat | fmt_i.sat;
         end
      end
   end

   // accumulator and output state; reset discards any partial frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r_q     <= '0;
         acc_i_q     <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         shift_q     <= '0;
         sum_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         pr_q        <= '0;
         pi_q        <= '0;
         sat_q       <= 1'b0;
      end else begin
         acc_r_q     <= acc_r_d;
         acc_i_q     <= acc_i_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         shift_q     <= shift_d;
         sum_valid_q <= sum_valid_d;
         out_valid_q <= out_valid_d;
         pr_q        <= pr_d;
         pi_q        <= pi_d;
         sat_q       <= sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign pr        = pr_q;
   assign pi        = pi_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_cmplx_mac.sv
// tb/tb_cmplx_mac.sv - self-checking bench for cmplx_mac
module tb_cmplx_mac;

   localparam int AW = 16;
   localparam int BW = 16;
   localparam int OW = 24;
   localparam int LW = 8;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [AW-1:0] ar = '0;
   logic signed [AW-1:0] ai = '0;
   logic signed [BW-1:0] br = '0;
   logic signed [BW-1:0] bi = '0;
   logic                 conj = 1'b0;
   logic [LW-1:0]        acc_len = 8'd1;
   logic [5:0]           shift = 6'd0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic signed [OW-1:0] pr;
   logic signed [OW-1:0] pi;
   logic                 sat_flag;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cmplx_mac #(
      .AWIDTH (AW),
      .BWIDTH (BW),
      .OWIDTH (OW),
      .LENW   (LW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ar        (ar),
      .ai        (ai),
      .br        (br),
      .bi        (bi),
      .conj      (conj),
      .acc_len   (acc_len),
      .shift     (shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pr        (pr),
      .pi        (pi),
      .sat_flag  (sat_flag)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: exact complex arithmetic, frame sums, round half up, clamp.
   longint run_r = 0, run_i = 0;
   int     run_n = 0, frame_len = 1, frame_sh = 0;
   longint exp_r[$], exp_i[$];
   int     exp_s[$];

   function automatic longint fmt(input longint v, input int sh, output int sat);
      longint r, hi, lo;
      r = v;
      if (sh > 0) r = (v + (longint'(1) << (sh - 1))) >>> sh;
      hi  = (longint'(1) << (OW - 1)) - 1;
      lo  = -hi - 1;
      sat = 0;
      if (r > hi) begin r = hi; sat = 1; end
      if (r < lo) begin r = lo; sat = 1; end
      return r;
   endfunction

   task automatic model_accept();
      longint a_r, a_i, b_r, b_i, v_r, v_i;
      int     s_r, s_i;
      a_r = ar; a_i = ai; b_r = br; b_i = bi;
      if (conj) b_i = -b_i;
      if (run_n == 0) begin
         frame_len = (acc_len == 0) ? 1 : int'(acc_len);
         frame_sh  = int'(shift);
         run_r = 0;
         run_i = 0;
      end
      run_r += a_r * b_r - a_i * b_i;
      run_i += a_r * b_i + a_i * b_r;
      run_n++;
      if (run_n == frame_len) begin
         v_r = fmt(run_r, frame_sh, s_r);
         v_i = fmt(run_i, frame_sh, s_i);
         exp_r.push_back(v_r);
         exp_i.push_back(v_i);
         exp_s.push_back(s_r | s_i);
         run_n = 0;
      end
   endtask

   logic signed [OW-1:0] hold_pr, hold_pi;
   logic                 hold_sat;
   bit                   was_stalled = 0;
   int                   stall_cycles = 0;

   // single compare process: model update on accept, checks on delivery and stall
   always @(negedge clk) begin
      if (rst) begin
         run_n = 0;
         exp_r.delete(); exp_i.delete(); exp_s.delete();
         was_stalled = 0;
      end else begin
         if (in_valid && in_ready) model_accept();
         if (out_valid && !out_ready) begin
            stall_cycles++;
            check("stall_in_ready", in_ready, 0);
            if (was_stalled) begin
               check("stall_hold_pr", pr, hold_pr);
               check("stall_hold_pi", pi, hold_pi);
               check("stall_hold_sat", sat_flag, hold_sat);
            end
            was_stalled = 1;
            hold_pr = pr; hold_pi = pi; hold_sat = sat_flag;
         end else begin
            was_stalled = 0;
         end
         if (out_valid && out_ready) begin
            if (exp_r.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL model_unexpected_output: got pr=%0d pi=%0d, expected no output", pr, pi);
            end else begin
               check("model_pr", pr, exp_r.pop_front());
               check("model_pi", pi, exp_i.pop_front());
               check("model_sat", sat_flag, exp_s.pop_front());
            end
         end
      end
   end

   // present a sample and return one time step after the edge that accepts it
   task automatic send(input int a_r, input int a_i, input int b_r, input int b_i, input bit cj);
      bit ok;
      ar = AW'(a_r); ai = AW'(a_i); br = BW'(b_r); bi = BW'(b_i); conj = cj;
      in_valid = 1'b1;
      ok = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected 1");
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      for (int t = 0; t < 400; t++) begin
         @(posedge clk); #1;
         n++;
         if (out_valid) return;
      end
      n_cmp++; n_err++;
      $display("FAIL wait_out_timeout: got out_valid=0 for 400 cycles, expected 1");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected $finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_pr", pr, 0);
      check("rst_pi", pi, 0);
      check("rst_sat", sat_flag, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);

      // plain product and latency
      acc_len = 8'd1; shift = 6'd0;
      send(3, 4, 5, -2, 1'b0);
      in_valid = 1'b0;
      wait_out(n);
      check("latency", n, 6);
      check("mul_pr", pr, 23);
      check("mul_pi", pi, 14);
      check("mul_sat", sat_flag, 0);

      // conjugate
      send(3, 4, 5, -2, 1'b1);
      in_valid = 1'b0;
      wait_out(n);
      check("conj_pr", pr, 7);
      check("conj_pi", pi, 26);

      // four-product frame with rounding shift
      acc_len = 8'd4; shift = 6'd2;
      for (int i = 0; i < 4; i++) send(1, 0, 100, 50, 1'b0);
      in_valid = 1'b0;
      wait_out(n);
      check("frame4_pr", pr, 100);
      check("frame4_pi", pi, 50);

      // long frame saturates
      acc_len = 8'd255; shift = 6'd0;
      for (int i = 0; i < 255; i++) send(32767, 0, 32767, 0, 1'b0);
      in_valid = 1'b0;
      wait_out(n);
      check("sat_pr", pr, 8388607);
      check("sat_pi", pi, 0);
      check("sat_flag", sat_flag, 1);

      // round half up on both signs
      acc_len = 8'd1; shift = 6'd1;
      send(3, 0, 1, 0, 1'b0);
      in_valid = 1'b0;
      wait_out(n);
      check("round_pos", pr, 2);
      send(-3, 0, 1, 0, 1'b0);
      in_valid = 1'b0;
      wait_out(n);
      check("round_neg", pr, -1);

      // acc_len 0 behaves as 1, including the most negative bi under conj
      acc_len = 8'd0; shift = 6'd0;
      send(-32768, 1, 1, -32768, 1'b1);
      in_valid = 1'b0;
      wait_out(n);
      check("len0_pr", pr, -65536);
      check("len0_pi", pi, -1073741823 + 8388607 - 8388607 < -8388608 ? -8388608 : 0);
      check("len0_sat", sat_flag, 1);

      // reset mid-frame drops the partial sum
      acc_len = 8'd4; shift = 6'd0;
      send(1, 0, 1000, 0, 1'b0);
      send(1, 0, 1000, 0, 1'b0);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", out_valid, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) send(1, 0, 10, 0, 1'b0);
      in_valid = 1'b0;
      wait_out(n);
      check("midrst_pr", pr, 40);
      check("midrst_pi", pi, 0);

      // continuous stream with a 10-cycle consumer stall
      repeat (4) @(posedge clk);
      #1;
      acc_len = 8'd1; shift = 6'd8;
      stall_cycles = 0;
      fork
         begin
            for (int i = 0; i < 40; i++)
               send(i * 1237 - 20000, 15000 - i * 911, i * 503 - 9000,
                    (i == 5) ? -32768 : 32000 - i * 1601, i[0]);
            in_valid = 1'b0;
         end
         begin
            repeat (12) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (20) @(posedge clk);
      #1;
      check("stall_cycles", stall_cycles, 10);
      check("model_queue_drained", exp_r.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cmplx_mac.md
CMPLX_MAC -- requirements
Module: cmplx_mac

Interface
REQ-001 Parameter AWIDTH, default 16: signed width of ar/ai.
REQ-002 Parameter BWIDTH, default 16: signed width of br/bi.
REQ-003 Parameter OWIDTH, default 24: signed width of pr/pi after rounding and saturation.
REQ-004 Parameter LENW, default 8: width of acc_len.
REQ-005 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-high.
REQ-007 Port in_valid  in  1  input sample valid.
REQ-008 Port in_ready  out  1  block accepts a sample on an edge where in_valid&in_ready.
REQ-009 Port ar, ai  in  AWIDTH each  signed operand a (real, imag).
REQ-010 Port br, bi  in  BWIDTH each  signed operand b (real, imag).
REQ-011 Port conj  in  1  sampled with data; 1 = a*conj(b), 0 = a*b.
REQ-012 Port acc_len  in  LENW  products per output frame; 0 is treated as 1.
REQ-013 Port shift  in  6  arithmetic right shift applied to the frame sum before saturation.
REQ-014 Port out_valid  out  1  result valid.
REQ-015 Port out_ready  in  1  consumer accepts on out_valid&out_ready.
REQ-016 Port pr, pi  out  OWIDTH each  signed result.
REQ-017 Port sat_flag  out  1  the current result saturated in pr or pi.

Function
REQ-018 Product SHALL be pr = ar*br - ai*bi and pi = ar*bi + ai*br, using three multipliers with the shared term (ar-ai)*bi; when conj=1, bi SHALL be negated into BWIDTH+1 bits so that -2^(BWIDTH-1) is exact.
REQ-019 Full product width SHALL be AWIDTH+BWIDTH+1, and the accumulator width SHALL be AWIDTH+BWIDTH+1+LENW with no internal overflow.
REQ-020 A global enable ce = !out_valid | out_ready SHALL advance every pipeline stage, and in_ready SHALL equal ce.
REQ-021 The multiplier pipeline SHALL be 4 ce-stages, followed by 1 accumulator stage and 1 output register; with acc_len=1 and no stall, a sample accepted at edge k SHALL be presented on pr/pi with out_valid=1 after edge k+6.
REQ-022 Each pipeline stage SHALL carry a valid bit, and bubbles (in_valid=0) SHALL NOT alter the accumulator or the count.
REQ-023 acc_len and shift SHALL be latched when the first product of a frame enters the accumulator stage; changes mid-frame SHALL take effect from the next frame.
REQ-024 When the product count reaches the latched acc_len, the sum SHALL pass to the output stage and the accumulator SHALL reload with the next valid product in the same cycle, so back-to-back frames have no bubble.
REQ-025 Output formatting: if shift>0, add 2^(shift-1) and then shift right arithmetically (round half up); saturate to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1]; sat_flag = saturated(pr) | saturated(pi).
REQ-026 While out_valid=1 and out_ready=0, pr, pi, sat_flag and all pipeline state SHALL hold; no sample SHALL be lost or reordered.

Reset
REQ-027 While rst=1: all valid bits, the accumulator, the count, out_valid, pr, pi and sat_flag SHALL be 0, and in_ready SHALL be 1 after release.
REQ-028 Reset mid-frame SHALL discard the partial sum; the first product accepted after release SHALL start a new frame.

Structure
REQ-029 Package cmplx_pkg SHALL hold the default widths, the MUL_LAT=4 constant and the round/saturate function.
REQ-030 Sub-module cmplx_mul_pipe SHALL implement the 3-multiplier ce-gated pipeline with conj and a valid bit; cmplx_mac SHALL add the accumulator, the frame counter and the output register.

Verification
REQ-031 acc_len=1, conj=0, shift=0, a=(3,4), b=(5,-2) -> pr=23, pi=14, out_valid 6 cycles after acceptance.
REQ-032 Same operands with conj=1 -> pr=7, pi=26.
REQ-033 acc_len=4, shift=2, four samples a=(1,0), b=(100,50) -> one output pr=100, pi=50; frame sum before shift is (400,200).
REQ-034 Defaults, acc_len=255, shift=0, a=(32767,0), b=(32767,0) repeated -> pr=8388607, pi=0, sat_flag=1.
REQ-035 shift=1, acc_len=1: a=(3,0), b=(1,0) -> pr=2; a=(-3,0), b=(1,0) -> pr=-1.
REQ-036 Continuous in_valid with out_ready held low for 10 cycles mid-stream -> in_ready=0 throughout the stall, outputs stable, and all results delivered in order against a reference model.
